tron_game_ctrl: RTL and testbench
=================================

# tron_game_ctrl

Game-sequencing controller for the two-player Tron display datapath. Owns the round state machine (idle, countdown, play, crash, game over), decides when player positions are held at their start points and when they may advance once per frame, and keeps per-player scores from collision results. Sits between the VGA timing/collision logic and the player-position registers. Its `dflt` and `move_en` outputs gate the end-of-frame position update.

## Interface
Parameters:
- `COUNTDOWN_FRAMES`, 180: frames spent in COUNTDOWN; must be ≥1.
- `CRASH_FRAMES`, 120: frames spent in CRASH freeze; must be ≥1.
- `WIN_SCORE`, 3: score that ends the game; range 1..15.

Ports:
- `clock`, in, 1: system clock. Reset is `reset`: synchronous, active-high; clock is `clock`.
- `reset`, in, 1: synchronous, active-high.
- `frame_end`, in, 1: one-cycle pulse at row 599, col 799.
- `start`, in, 1: synchronized start button, level.
- `pause`, in, 1: synchronized pause button, level. Used only with `TRON_PAUSE_EN`.
- `p1_crash`, in, 1: player 1 collided this frame; valid when `frame_end` is high.
- `p2_crash`, in, 1: player 2 collided this frame; valid when `frame_end` is high.
- `dflt`, out, 1: force player positions to their start points.
- `move_en`, out, 1: positions may update on this `frame_end`.
- `p1_score`, out, 4: player 1 score.
- `p2_score`, out, 4: player 2 score.
- `round_result`, out, 2: 00 none, 01 P1 won round, 10 P2 won round, 11 draw.
- `winner`, out, 2: 00 none, 01 P1, 10 P2.
- `state`, out, 3: current state encoding.

## Operation
- State encodings: IDLE=0, COUNTDOWN=1, PLAY=2, CRASH=3, GAME_OVER=4, PAUSED=5.
- All outputs are registered or decoded directly from registered state. No input-to-output combinational paths.
- `start` and `pause` are edge-detected internally; only a 0→1 transition counts.
- Frame timer:
  - Loaded with N−1 on entry to a timed state.
  - Decrements on each `frame_end`.
  - When `frame_end` arrives with the timer at 0, the state exits. The state therefore lasts exactly N `frame_end` pulses.
- IDLE:
  - `dflt`=1, `move_en`=0.
  - Start edge → COUNTDOWN; scores, `round_result` and `winner` cleared.
- COUNTDOWN:
  - `dflt`=1, `move_en`=0.
  - After `COUNTDOWN_FRAMES` → PLAY; `round_result` cleared.
- PLAY:
  - `dflt`=0, `move_en`=1.
  - On `frame_end`, crash flags are sampled:
    - neither → stay in PLAY;
    - P1 only → `p2_score`+1, `round_result`=10;
    - P2 only → `p1_score`+1, `round_result`=01;
    - both → draw, `round_result`=11, no score change.
  - Any crash → CRASH. `move_en` drops the cycle after, so the crashing frame's position update is still applied.
- CRASH:
  - `dflt`=0, `move_en`=0 (positions frozen).
  - After `CRASH_FRAMES`: if either score equals `WIN_SCORE` → GAME_OVER; otherwise → COUNTDOWN.
- GAME_OVER:
  - `dflt`=0, `move_en`=0.
  - `winner` = the player whose score equals `WIN_SCORE`.
  - Start edge → COUNTDOWN; scores and `winner` cleared.
- Scores saturate at `WIN_SCORE`; they never exceed it.
- Crash flags are ignored outside PLAY.
- Start edges are ignored in COUNTDOWN, PLAY, CRASH and PAUSED.
- State 6 or 7 (illegal) → IDLE on the next cycle.

## Timing
- Reset values:
  - state IDLE, `dflt`=1, `move_en`=0;
  - scores 0, `round_result`=00, `winner`=00;
  - timer 0, edge-detect history 0.
- Reset overrides every input in the same cycle, including mid-round or a simultaneous `frame_end`.
- State transitions take effect the clock after the qualifying `frame_end` or start edge.
- Start edge latency: the edge is detected the cycle after `start` rises; the state changes one cycle later.
- `frame_end` coinciding with a start or pause edge: the edge takes priority only in states where it is legal. In PLAY, a crash beats pause.
- Timers advance only on `frame_end`. Clock cycles between frames do not count.

## Configuration
- `TRON_PAUSE_EN` defined:
  - Pause edge in PLAY (with no crash on that cycle) → PAUSED.
  - PAUSED: `dflt`=0, `move_en`=0; crash flags ignored.
  - Pause edge in PAUSED → PLAY.
- `TRON_PAUSE_EN` undefined: the `pause` port exists but is ignored, PAUSED is unreachable, and encoding 5 is treated as illegal (→ IDLE).

## Test plan
Bench parameters: `COUNTDOWN_FRAMES`=3, `CRASH_FRAMES`=2, `WIN_SCORE`=2.

- **Reset/start:** assert reset → state=0, `dflt`=1, `move_en`=0, scores 0. Pulse `start` → state=1. After 3 `frame_end` → state=2, `move_en`=1.
- **Single crash:** in PLAY, `frame_end` with `p1_crash`=1 → `p2_score`=1, `round_result`=10, state=3. After 2 frames → state=1 with `dflt`=1.
- **Draw:** in PLAY, both crash flags on `frame_end` → scores unchanged, `round_result`=11, state=3.
- **Game over:** P1 wins two rounds → `p1_score`=2, state=4 after CRASH, `winner`=01. Start edge → state=1, scores 0, `winner`=00.
- **Reset mid-CRASH with simultaneous `frame_end`:** → state=0, timer and scores cleared the next cycle.
- **`TRON_PAUSE_EN`:** pause edge in PLAY → state=5, `move_en`=0; `p1_crash` is ignored there. Second pause edge → state=2. Built without the macro, the same stimulus keeps state=2.

Source files
------------

// File: rtl/tron_game_ctrl.sv
// tron_game_ctrl: round sequencer for two-player Tron (idle, countdown, play, crash, game over, optional pause)
// Ports: clock/reset (sync, active-high); frame_end pulse; start/pause button levels;
// p1_crash/p2_crash sampled on frame_end; dflt/move_en gate position update;
// p1_score/p2_score, round_result, winner, state are all registered.
// Optional feature: define TRON_PAUSE_EN to enable the PAUSED state.
module tron_game_ctrl #(
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int CRASH_FRAMES = 120,
  parameter int WIN_SCORE = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       start,
  input  logic       pause,
  input  logic       p1_crash,
  input  logic       p2_crash,
  output logic       dflt,
  output logic       move_en,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] round_result,
  output logic [1:0] winner,
  output logic [2:0] state
);
  localparam int MAXF = COUNTDOWN_FRAMES > CRASH_FRAMES ? COUNTDOWN_FRAMES : CRASH_FRAMES;
  localparam int TW = MAXF > 1 ? $clog2(MAXF) : 1;
  localparam logic [TW-1:0] CD_LOAD = TW'(COUNTDOWN_FRAMES - 1);
  localparam logic [TW-1:0] CR_LOAD = TW'(CRASH_FRAMES - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_CD = 3'd1, S_PLAY = 3'd2, S_CRASH = 3'd3, S_OVER = 3'd4, S_PAUSED = 3'd5
  } state_t;
  state_t cur, nxt;
  logic [TW-1:0] timer, timer_n;
  logic [3:0] p1_n, p2_n;
  logic [1:0] rr_n, win_n;
  logic start_d, start_dd, start_edge;
  // Edges come from registered history only, so no input reaches an output combinationally.
  assign start_edge = start_d & ~start_dd;
`ifdef TRON_PAUSE_EN
  logic pause_d, pause_dd, pause_edge;
  assign pause_edge = pause_d & ~pause_dd;
  always_ff @(posedge clock)
    if (reset) {pause_d, pause_dd} <= 2'b00;
    else {pause_d, pause_dd} <= {pause, pause_d};
`else
  logic pause_unused;
  assign pause_unused = pause;
`endif
  assign state = cur;
  assign dflt = (cur == S_IDLE) || (cur == S_CD);
  assign move_en = cur == S_PLAY;
  always_comb begin
    nxt = cur;
    timer_n = timer;
    p1_n = p1_score;
    p2_n = p2_score;
    rr_n = round_result;
    win_n = winner;
    case (cur)
      S_IDLE, S_OVER:
        if (start_edge) begin
          nxt = S_CD;
          timer_n = CD_LOAD;
          p1_n = '0;
          p2_n = '0;
          win_n = '0;
          if (cur == S_IDLE) rr_n = '0;
        end
      S_CD:
        if (frame_end) begin
          if (timer == '0) begin
            nxt = S_PLAY;
            rr_n = '0;
          end else timer_n = timer - TW'(1);
        end
      S_PLAY:
        if (frame_end && (p1_crash || p2_crash)) begin
          nxt = S_CRASH;
          timer_n = CR_LOAD;
          rr_n = {p1_crash, p2_crash};
          if (p1_crash && !p2_crash && p2_score < WIN) p2_n = p2_score + 4'd1;
          if (p2_crash && !p1_crash && p1_score < WIN) p1_n = p1_score + 4'd1;
        end
`ifdef TRON_PAUSE_EN
        else if (pause_edge) nxt = S_PAUSED;
`endif
      S_CRASH:
        if (frame_end) begin
          if (timer != '0) timer_n = timer - TW'(1);
          else if (p1_score == WIN || p2_score == WIN) begin
            nxt = S_OVER;
            win_n = p1_score == WIN ? 2'b01 : 2'b10;
          end else begin
            nxt = S_CD;
            timer_n = CD_LOAD;
          end
        end
`ifdef TRON_PAUSE_EN
      S_PAUSED: if (pause_edge) nxt = S_PLAY;
`endif
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      cur <= S_IDLE;
      timer <= '0;
      p1_score <= '0;
      p2_score <= '0;
      round_result <= '0;
      winner <= '0;
      {start_d, start_dd} <= 2'b00;
    end else begin
      cur <= nxt;
      timer <= timer_n;
      p1_score <= p1_n;
      p2_score <= p2_n;
      round_result <= rr_n;
      winner <= win_n;
      {start_d, start_dd} <= {start, start_d};
    end
endmodule

// File: tb/tb_tron_game_ctrl.sv
// tb_tron_game_ctrl: table-driven checks of round sequencing, scoring, game over, reset and pause
module tb_tron_game_ctrl;
  logic clock = 0, reset = 1, frame_end = 0, start = 0, pause = 0, p1_crash = 0, p2_crash = 0;
  logic dflt, move_en;
  logic [3:0] p1_score, p2_score;
  logic [1:0] round_result, winner;
  logic [2:0] state;
  int errors = 0, checks = 0;
`ifdef TRON_PAUSE_EN
  localparam logic [2:0] PS = 3'd5;
  localparam logic PM = 1'b0, PFE = 1'b1;
`else
  localparam logic [2:0] PS = 3'd2;
  localparam logic PM = 1'b1, PFE = 1'b0;
`endif
  tron_game_ctrl #(.COUNTDOWN_FRAMES(3), .CRASH_FRAMES(2), .WIN_SCORE(2)) dut (
    .clock(clock), .reset(reset), .frame_end(frame_end), .start(start), .pause(pause),
    .p1_crash(p1_crash), .p2_crash(p2_crash), .dflt(dflt), .move_en(move_en),
    .p1_score(p1_score), .p2_score(p2_score), .round_result(round_result),
    .winner(winner), .state(state)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic r, s, p, f, a, b;
    logic [2:0] es;
    logic ed, em;
    logic [3:0] e1, e2;
    logic [1:0] er, ew;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(input logic r, s, p, f, a, b, input logic [2:0] es,
                              input logic ed, em, input logic [3:0] e1, e2,
                              input logic [1:0] er, ew);
    vec_t t;
    t.r = r; t.s = s; t.p = p; t.f = f; t.a = a; t.b = b;
    t.es = es; t.ed = ed; t.em = em; t.e1 = e1; t.e2 = e2; t.er = er; t.ew = ew;
    return t;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic apply(input int i, input vec_t t);
    {reset, start, pause, frame_end, p1_crash, p2_crash} = {t.r, t.s, t.p, t.f, t.a, t.b};
    @(posedge clock);
    #1;
    chk($sformatf("row%0d state", i), state, t.es);
    chk($sformatf("row%0d dflt", i), dflt, t.ed);
    chk($sformatf("row%0d move_en", i), move_en, t.em);
    chk($sformatf("row%0d p1_score", i), p1_score, t.e1);
    chk($sformatf("row%0d p2_score", i), p2_score, t.e2);
    chk($sformatf("row%0d round_result", i), round_result, t.er);
    chk($sformatf("row%0d winner", i), winner, t.ew);
  endtask
  initial begin
    // rst st pa fe c1 c2 | state dflt move p1 p2 rr win
    v.push_back(mk(1,0,0,0,0,0, 0,1,0, 0,0,0,0));
    v.push_back(mk(0,1,0,0,0,0, 0,1,0, 0,0,0,0));
    v.push_back(mk(0,0,0,0,0,0, 1,1,0, 0,0,0,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 0,0,0,0));
    v.push_back(mk(0,0,0,0,0,0, 1,1,0, 0,0,0,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 0,0,0,0));
    v.push_back(mk(0,0,0,1,0,0, 2,0,1, 0,0,0,0));
    v.push_back(mk(0,0,0,1,0,0, 2,0,1, 0,0,0,0));
    v.push_back(mk(0,0,0,1,1,0, 3,0,0, 0,1,2,0));
    v.push_back(mk(0,0,0,1,1,0, 3,0,0, 0,1,2,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 0,1,2,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 0,1,2,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 0,1,2,0));
    v.push_back(mk(0,0,0,1,0,0, 2,0,1, 0,1,0,0));
    v.push_back(mk(0,0,0,1,1,1, 3,0,0, 0,1,3,0));
    v.push_back(mk(0,0,0,1,0,0, 3,0,0, 0,1,3,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 0,1,3,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 0,1,3,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 0,1,3,0));
    v.push_back(mk(0,0,0,1,0,0, 2,0,1, 0,1,0,0));
    v.push_back(mk(0,0,0,1,0,1, 3,0,0, 1,1,1,0));
    v.push_back(mk(0,0,0,1,0,0, 3,0,0, 1,1,1,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 1,1,1,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 1,1,1,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 1,1,1,0));
    v.push_back(mk(0,0,0,1,0,0, 2,0,1, 1,1,0,0));
    v.push_back(mk(0,0,0,1,0,1, 3,0,0, 2,1,1,0));
    v.push_back(mk(0,0,0,1,0,0, 3,0,0, 2,1,1,0));
    v.push_back(mk(0,0,0,1,0,0, 4,0,0, 2,1,1,1));
    v.push_back(mk(0,1,0,0,0,0, 4,0,0, 2,1,1,1));
    v.push_back(mk(0,1,0,0,0,0, 1,1,0, 0,0,1,0));
    v.push_back(mk(0,1,0,0,0,0, 1,1,0, 0,0,1,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 0,0,1,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 0,0,1,0));
    v.push_back(mk(0,0,0,1,0,0, 2,0,1, 0,0,0,0));
    v.push_back(mk(0,0,1,0,0,0, 2,0,1, 0,0,0,0));
    v.push_back(mk(0,0,0,0,0,0, PS,0,PM, 0,0,0,0));
    v.push_back(mk(0,0,0,PFE,1,0, PS,0,PM, 0,0,0,0));
    v.push_back(mk(0,0,1,0,0,0, PS,0,PM, 0,0,0,0));
    v.push_back(mk(0,0,0,0,0,0, 2,0,1, 0,0,0,0));
    v.push_back(mk(0,0,1,0,0,0, 2,0,1, 0,0,0,0));
    v.push_back(mk(0,0,0,1,1,0, 3,0,0, 0,1,2,0));
    v.push_back(mk(0,0,0,1,0,0, 3,0,0, 0,1,2,0));
    v.push_back(mk(1,0,0,1,0,0, 0,1,0, 0,0,0,0));
    v.push_back(mk(0,1,0,0,0,0, 0,1,0, 0,0,0,0));
    v.push_back(mk(0,0,0,0,0,0, 1,1,0, 0,0,0,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 0,0,0,0));
    v.push_back(mk(0,0,0,1,0,0, 1,1,0, 0,0,0,0));
    v.push_back(mk(0,0,0,1,0,0, 2,0,1, 0,0,0,0));
    for (int i = 0; i < v.size(); i++) apply(i, v[i]);
    // start edges must not disturb PLAY; frames without crashes keep it there
    start = 1;
    for (int i = 0; i < 4; i++) begin
      frame_end = i[0];
      @(posedge clock);
      #1;
      chk($sformatf("play_start_ignored%0d", i), state, 2);
      chk($sformatf("play_move_en%0d", i), move_en, 1);
    end
    {start, frame_end} = 2'b00;
    // crash flags without frame_end are not sampled
    {p1_crash, p2_crash} = 2'b11;
    @(posedge clock);
    #1;
    chk("crash_no_frame state", state, 2);
    chk("crash_no_frame p1", p1_score, 0);
    {p1_crash, p2_crash} = 2'b00;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
